// File: rtl/sound_event_encoder_if.sv
// Bus between the game logic and the sound event encoder.
// Event pulses go toward the encoder. The strobe, code and status signals come back.
// The strobe is a one-way single-cycle pulse with no ready signal.
// The code is meaningful only in the cycle where sound_trigger_out is high; at all other times it is zero.
interface sound_event_encoder_if #(
    parameter int M = 2
);
    logic         evt_eat_food;
    logic         evt_game_over;
    logic         evt_start;
    logic [M-1:0] sound_event_code_out;
    logic         sound_trigger_out;
    logic         busy;
    logic         queue_full;
    logic [7:0]   drop_count;
    logic [1:0]   fsm_state;

    modport master (
        output evt_eat_food, evt_game_over, evt_start,
        input  sound_event_code_out, sound_trigger_out, busy, queue_full,
               drop_count, fsm_state
    );

    modport slave (
        input  evt_eat_food, evt_game_over, evt_start,
        output sound_event_code_out, sound_trigger_out, busy, queue_full,
               drop_count, fsm_state
    );
endinterface

// File: rtl/sound_event_encoder.sv
// Sound event encoder.
// Game event pulses are prioritised, queued in a small FIFO and issued one at a time.
// Each issued sound is followed by a hold-off time that depends on the event.
// A GAME_OVER event flushes the queue.
// fsm_state shows the issue FSM state for debug (0=IDLE, 1=ISSUE, 2=WAIT).
module sound_event_encoder #(
    parameter int M        = 2,
    parameter int CLK_FREQ = 100_000_000,
    parameter int QDEPTH   = 4,
    parameter int GUARD    = 2
) (
    input  logic clk,
    input  logic reset_n,
    sound_event_encoder_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);

    localparam logic [M-1:0] CODE_NONE = M'(0);
    localparam logic [M-1:0] CODE_EAT  = M'(1);
    localparam logic [M-1:0] CODE_GO   = M'(2);
    localparam logic [M-1:0] CODE_ST   = M'(3);

    localparam logic [31:0] HOLD_EAT = 32'(CLK_FREQ / 20) + 32'(GUARD);
    localparam logic [31:0] HOLD_GO  = 32'(CLK_FREQ / 2)  + 32'(GUARD);
    localparam logic [31:0] HOLD_ST  = 32'(CLK_FREQ / 10) + 32'(GUARD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [M-1:0]  mem [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [M-1:0]  cur_code;
    logic [31:0]   hold_cnt;
    logic [31:0]   hold_val;
    logic [7:0]    drop_cnt;

    logic          acc_go, acc_st, acc_eat;
    logic          push_req, push_ok, cap_drop, pop, full;
    logic [1:0]    n_evt, prio_drops, drops_now;
    logic [M-1:0]  push_code;
    logic [8:0]    drop_sum;

    // Event priority, FIFO push/pop qualification and drop accounting
    always_comb begin
        acc_go     = bus.evt_game_over;
        acc_st     = bus.evt_start & ~bus.evt_game_over;
        acc_eat    = bus.evt_eat_food & ~bus.evt_game_over & ~bus.evt_start;
        n_evt      = 2'(bus.evt_eat_food) + 2'(bus.evt_game_over) + 2'(bus.evt_start);
        prio_drops = (n_evt != 2'd0) ? n_evt - 2'd1 : 2'd0;
        full       = (count == (PW+1)'(QDEPTH));
        pop        = (state == S_IDLE) && (count != '0);
        push_req   = acc_st | acc_eat;
        push_code  = acc_st ? CODE_ST : CODE_EAT;
        // A full queue still accepts a push when the head leaves in the same cycle
        push_ok    = push_req && (!full || pop);
        cap_drop   = push_req && full && !pop;
        drops_now  = prio_drops + 2'(cap_drop);
        drop_sum   = {1'b0, drop_cnt} + 9'(drops_now);
    end

    // Queue storage; contents are don't-care while the queue is empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (acc_go)
            mem[0] <= CODE_GO;
        else if (push_ok)
            mem[wr_ptr] <= push_code;
    end

    // Queue pointers and occupancy; GAME_OVER flushes the queue and becomes the only entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (acc_go) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(1);
            count  <= (PW+1)'(1);
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end

    // Capture the popped head; the read sees the old head even in a flush cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cur_code <= CODE_NONE;
        else if (pop)
            cur_code <= mem[rd_ptr];
    end

    // Saturating count of discarded events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt <= 8'd0;
        else if (drop_sum > 9'd255)
            drop_cnt <= 8'd255;
        else
            drop_cnt <= drop_sum[7:0];
    end

    // Hold-off length for the sound currently being issued
    always_comb begin
        case (cur_code)
            CODE_EAT: hold_val = HOLD_EAT;
            CODE_GO:  hold_val = HOLD_GO;
            CODE_ST:  hold_val = HOLD_ST;
            default:  hold_val = 32'd0;
        endcase
    end

    // Hold-off counter: loaded during ISSUE, counted down during WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold_cnt <= 32'd0;
        else if (state == S_ISSUE)
            hold_cnt <= hold_val;
        else if (state == S_WAIT && hold_cnt != 32'd0)
            hold_cnt <= hold_cnt - 32'd1;
    end

    // Issue FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Issue FSM next state; WAIT leaves in the cycle where the counter would reach zero
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pop) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (hold_cnt <= 32'd1) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Issue FSM outputs and status
    always_comb begin
        bus.sound_trigger_out    = (state == S_ISSUE);
        bus.sound_event_code_out = (state == S_ISSUE) ? cur_code : CODE_NONE;
        bus.busy                 = (state != S_IDLE);
        bus.queue_full           = full;
        bus.drop_count           = drop_cnt;
        bus.fsm_state            = state;
    end
endmodule

// File: doc/sound_event_encoder.md
SOUND_EVENT_ENCODER -- requirements
Module: sound_event_encoder

Interface
REQ-001 SHALL have parameter M, default 2, the event code width.
REQ-002 SHALL have parameter CLK_FREQ, default 100_000_000, the system clock in Hz, used for hold-off timing.
REQ-003 SHALL have parameter QDEPTH, default 4, the pending-event queue depth (power of two, at least 2).
REQ-004 SHALL have parameter GUARD, default 2, the extra idle cycles added after each hold-off.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 evt_eat_food  input  1  single-cycle game event pulse.
REQ-008 evt_game_over  input  1  single-cycle game event pulse.
REQ-009 evt_start  input  1  single-cycle game event pulse.
REQ-010 sound_event_code_out  output  M  event code, valid only while sound_trigger_out=1, otherwise 00.
REQ-011 sound_trigger_out  output  1  single-cycle issue strobe to the sound controller.
REQ-012 busy  output  1  high while an issued sound is considered playing (ISSUE or WAIT).
REQ-013 queue_full  output  1  high when the queue holds QDEPTH entries.
REQ-014 drop_count  output  8  saturating count of discarded events.

Function
REQ-015 Codes SHALL be: NONE=00, EAT_FOOD=01, GAME_OVER=10, START=11; NONE is never queued or issued.
REQ-016 Simultaneous events in one cycle: only the highest priority SHALL be accepted (GAME_OVER > START > EAT_FOOD); each other asserted event SHALL increment drop_count once.
REQ-017 An accepted EAT_FOOD or START SHALL be pushed to the FIFO tail; if the queue is full and no pop occurs that cycle, it SHALL be dropped and drop_count incremented.
REQ-018 A push in the same cycle as a pop SHALL be accepted even when the queue is full.
REQ-019 An accepted GAME_OVER SHALL flush all queued entries (flushed entries do not count as drops) and leave GAME_OVER as the sole entry; a pop in the same cycle SHALL still take the old head.
REQ-020 drop_count SHALL saturate at 255 and increment by the number of events dropped in that cycle (at most 2 per cycle).
REQ-021 Issue FSM states: IDLE, ISSUE, WAIT.
REQ-022 IDLE: if the queue is non-empty, pop the head, go to ISSUE next cycle; otherwise stay.
REQ-023 ISSUE (exactly 1 cycle): sound_trigger_out=1 and sound_event_code_out=popped code; load hold-off counter; go to WAIT.
REQ-024 Hold-off value SHALL be D+GAUD where D: EAT_FOOD=CLK_FREQ/20, GAME_OVER=CLK_FREQ/2, START=CLK_FREQ/10; D uses integer division and a 32-bit counter.
REQ-025 WAIT: decrement the counter each cycle; when it reaches 0, go to IDLE; the next pop SHALL occur no earlier than that IDLE cycle.
REQ-026 Latency: an event arriving into an empty queue in IDLE at cycle t SHALL be popped at t+1 and strobed at t+2.
REQ-027 Strobes SHALL be spaced at least hold-off+2 cycles apart.
REQ-028 An accepted GAME_OVER during WAIT SHALL NOT abort the current hold-off.

Reset
REQ-029 On reset_n=0, asynchronously: FSM=IDLE, queue empty, counter=0, sound_trigger_out=0, sound_event_code_out=00, busy=0, queue_full=0, drop_count=0.
REQ-030 Reset asserted mid-WAIT or mid-ISSUE SHALL discard all pending and in-flight events; no strobe SHALL occur after release until a new event arrives.

Verification (CLK_FREQ=1000, QDEPTH=4, GUARD=2)
REQ-031 Single evt_eat_food at cycle 10 -> strobe code 01 at cycle 12; busy high for cycles 12..64; no further strobe.
REQ-032 evt_game_over, evt_start, and evt_eat_food in the same cycle -> one strobe with code 10; drop_count=2.
REQ-033 evt_start, then 5 evt_eat_food pulses in the following cycles during WAIT -> strobes 11,01,01,01,01 spaced >=104 and >=54 cycles apart; queue_full observed; drop_count=1.
REQ-034 Queue holding 3 EAT_FOOD entries during WAIT, then evt_game_over -> queue flushed; next strobe code 10; drop_count unchanged.
REQ-035 reset_n pulsed low during WAIT with 2 entries queued -> all outputs 0 immediately; no strobe within 1000 cycles after release.
REQ-036 260 dropped events -> drop_count holds at 255.
